// File: rtl/spi_master_param.sv
// Parametrised SPI master: one full-duplex word per chip-select assertion, all four modes, MSB/LSB first.
// Optional feature macro: SPI_LOOPBACK_EN adds a loopback input that feeds the MOSI register back into the sampler.
module spi_master_param #(
    parameter int DATA_W  = 8,
    parameter int CLK_DIV = 2,
    parameter int NUM_CS  = 1
) (
    input  logic                      clk,
    input  logic                      rst,
`ifdef SPI_LOOPBACK_EN
    input  logic                      loopback,
`endif
    // tx_valid/tx_ready: a word transfers on a rising edge where both are high; the host holds
    // tx_valid and tx_data stable until then. rx_valid is a one-cycle pulse with no backpressure.
    input  logic                      tx_valid,
    output logic                      tx_ready,
    input  logic [DATA_W-1:0]         tx_data,
    input  logic [$clog2(NUM_CS):0]   tx_cs_sel,
    input  logic                      cfg_cpol,
    input  logic                      cfg_cpha,
    input  logic                      cfg_lsb,
    output logic                      rx_valid,
    output logic [DATA_W-1:0]         rx_data,
    output logic                      busy,
    output logic                      SPI_CLK,
    output logic                      SPI_MOSI,
    input  logic                      SPI_MISO,
    output logic [NUM_CS-1:0]         SPI_CS_N,
    output logic [2:0]                state_dbg
);

    localparam int SEL_W  = $clog2(NUM_CS) + 1;
    localparam int DIV_W  = $clog2(CLK_DIV + 1);
    localparam int EDGE_W = $clog2(2 * DATA_W);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        XFER  = 3'd2,
        HOLD  = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t              state, next_state;
    logic [DIV_W-1:0]    div_cnt;
    logic [EDGE_W-1:0]   edge_cnt;
    logic [DATA_W-1:0]   shift_tx, shift_rx, tx_ordered;
    logic [NUM_CS-1:0]   cs_decode;
    logic                cpha_q, lsb_q;
    logic                div_end, last_edge, lead_edge, do_shift, do_sample, accept, miso_in;

    function automatic logic [DATA_W-1:0] bit_rev(input logic [DATA_W-1:0] v);
        logic [DATA_W-1:0] r;
        for (int i = 0; i < DATA_W; i++) r[i] = v[DATA_W-1-i];
        return r;
    endfunction

`ifdef SPI_LOOPBACK_EN
    assign miso_in = loopback ? SPI_MOSI : SPI_MISO;
`else
    assign miso_in = SPI_MISO;
`endif

    assign busy      = (state != IDLE);
    assign state_dbg = state;

    always_comb begin
        div_end    = (div_cnt == DIV_W'(CLK_DIV - 1));
        last_edge  = (edge_cnt == EDGE_W'(2 * DATA_W - 1));
        // edge_cnt even means the next SCLK edge is the leading one of its pulse
        lead_edge  = ~edge_cnt[0];
        do_shift   = cpha_q ? lead_edge : (~lead_edge & ~last_edge);
        do_sample  = cpha_q ? ~lead_edge : lead_edge;
        accept     = tx_valid & tx_ready;
        tx_ordered = cfg_lsb ? bit_rev(tx_data) : tx_data;
        for (int i = 0; i < NUM_CS; i++) cs_decode[i] = (tx_cs_sel != SEL_W'(i));
        next_state = state;
        case (state)
            IDLE:    if (accept) next_state = SETUP;
            SETUP:   if (div_end) next_state = XFER;
            XFER:    if (div_end && last_edge) next_state = HOLD;
            HOLD:    if (div_end) next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) state <= IDLE;
        else      state <= next_state;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            tx_ready <= 1'b0;
            rx_valid <= 1'b0;
            rx_data  <= '0;
            SPI_CLK  <= 1'b0;
            SPI_MOSI <= 1'b0;
            SPI_CS_N <= '1;
            div_cnt  <= '0;
            edge_cnt <= '0;
            shift_tx <= '0;
            shift_rx <= '0;
            cpha_q   <= 1'b0;
            lsb_q    <= 1'b0;
        end else begin
            tx_ready <= (next_state == IDLE);
            rx_valid <= 1'b0;
            if (state == SETUP || state == XFER || state == HOLD)
                div_cnt <= div_end ? '0 : div_cnt + 1'b1;
            else
                div_cnt <= '0;
            case (state)
                IDLE: begin
                    SPI_CLK  <= cfg_cpol;
                    SPI_MOSI <= 1'b0;
                    if (accept) begin
                        cpha_q   <= cfg_cpha;
                        lsb_q    <= cfg_lsb;
                        SPI_CS_N <= cs_decode;
                        shift_rx <= '0;
                        // CPHA=0 needs the first bit on the wire before the first leading edge
                        if (!cfg_cpha) begin
                            SPI_MOSI <= tx_ordered[DATA_W-1];
                            shift_tx <= tx_ordered << 1;
                        end else begin
                            shift_tx <= tx_ordered;
                        end
                    end
                end
                XFER: begin
                    if (div_end) begin
                        SPI_CLK  <= ~SPI_CLK;
                        edge_cnt <= last_edge ? '0 : edge_cnt + 1'b1;
                        if (do_shift) begin
                            SPI_MOSI <= shift_tx[DATA_W-1];
                            shift_tx <= shift_tx << 1;
                        end
                        if (do_sample) shift_rx <= {shift_rx[DATA_W-2:0], miso_in};
                    end
                end
                HOLD: begin
                    if (div_end) begin
                        SPI_CS_N <= '1;
                        SPI_MOSI <= 1'b0;
                        rx_valid <= 1'b1;
                        rx_data  <= lsb_q ? bit_rev(shift_rx) : shift_rx;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_master_param.sv
// Bench for spi_master_param (DATA_W=8, CLK_DIV=2, NUM_CS=4): table vectors, random transfers
// against a bit-stream slave model, reset abort and back-to-back sequences.
module tb_spi_master_param;
    localparam int DW   = 8;
    localparam int DIV  = 2;
    localparam int NCS  = 4;
    localparam int XLAT = (2 * DW + 2) * DIV;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic           tx_valid = 1'b0;
    logic           tx_ready;
    logic [DW-1:0]  tx_data = '0;
    logic [2:0]     tx_cs_sel = '0;
    logic           cfg_cpol = 1'b0, cfg_cpha = 1'b0, cfg_lsb = 1'b0;
    logic           rx_valid;
    logic [DW-1:0]  rx_data;
    logic           busy;
    logic           SPI_CLK, SPI_MOSI, SPI_MISO;
    logic [NCS-1:0] SPI_CS_N;
    logic [2:0]     state_dbg;
`ifdef SPI_LOOPBACK_EN
    logic           loopback = 1'b0;
`endif

    spi_master_param #(.DATA_W(DW), .CLK_DIV(DIV), .NUM_CS(NCS)) dut (
        .clk(clk), .rst(rst),
`ifdef SPI_LOOPBACK_EN
        .loopback(loopback),
`endif
        .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_data(tx_data), .tx_cs_sel(tx_cs_sel),
        .cfg_cpol(cfg_cpol), .cfg_cpha(cfg_cpha), .cfg_lsb(cfg_lsb),
        .rx_valid(rx_valid), .rx_data(rx_data), .busy(busy),
        .SPI_CLK(SPI_CLK), .SPI_MOSI(SPI_MOSI), .SPI_MISO(SPI_MISO), .SPI_CS_N(SPI_CS_N),
        .state_dbg(state_dbg)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard ----------------
    int n_tests = 0;
    int n_fail  = 0;
    logic [DW-1:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- slave model: works purely from the SCLK edge count ----------------
    logic [DW-1:0] s_word = '0;
    bit            s_cpha = 0, s_lsb = 0, slave_on = 0;
    int            s_edges = 0, cap_n = 0;
    int            arm_req = 0, arm_seen = 0;
    logic [DW-1:0] cap_word = '0;
    event          arm_ev;

    always begin
        @(SPI_CLK or arm_ev);
        if (arm_seen != arm_req) begin
            arm_seen = arm_req;
            s_edges  = 0;
            cap_n    = 0;
            cap_word = '0;
        end else if (slave_on) begin
            s_edges++;
            if (((s_edges % 2) == 1) != s_cpha) begin
                if (cap_n < DW) begin
                    if (s_lsb) cap_word[cap_n] = SPI_MOSI;
                    else       cap_word[DW-1-cap_n] = SPI_MOSI;
                end
                cap_n++;
            end
        end
    end

    always_comb begin
        int idx;
        idx = s_cpha ? ((s_edges > 0) ? (s_edges - 1) / 2 : 0) : s_edges / 2;
        if (idx > DW - 1) idx = DW - 1;
        SPI_MISO = s_lsb ? s_word[idx] : s_word[DW-1-idx];
    end

    function automatic logic [NCS-1:0] exp_cs(input logic [2:0] sel);
        return (sel < NCS) ? ~(NCS'(1) << sel) : {NCS{1'b1}};
    endfunction

    // ---------------- driver tasks ----------------
    task automatic arm_slave(input logic [DW-1:0] slv, input bit cpha, input bit lsb);
        slave_on = 0;
        s_word = slv; s_cpha = cpha; s_lsb = lsb;
        arm_req++;
        -> arm_ev;
        #0;
        slave_on = 1;
    endtask

    task automatic start_xfer(input logic [DW-1:0] tx, input logic [DW-1:0] slv, input bit cpol,
                              input bit cpha, input bit lsb, input logic [2:0] sel,
                              input logic [DW-1:0] exp_rx, input bit hold, output int acc);
        @(negedge clk);
        slave_on = 0;
        cfg_cpol = cpol; cfg_cpha = cpha; cfg_lsb = lsb; tx_cs_sel = sel; tx_data = tx;
        @(negedge clk);
        @(negedge clk);
        check("idle_sclk", SPI_CLK, cpol);
        arm_slave(slv, cpha, lsb);
        exp_q.push_back(exp_rx);
        tx_valid = 1'b1;
        acc = -1;
        for (int i = 0; i < 200; i++) begin
            if (tx_ready) begin acc = cyc + 1; break; end
            @(negedge clk);
        end
        if (acc < 0) begin
            check("accept_timeout", 0, 1);
            tx_valid = 1'b0;
        end else begin
            @(posedge clk);
            #1;
            if (!hold) tx_valid = 1'b0;
        end
    endtask

    task automatic finish_xfer(input int acc, input logic [DW-1:0] tx, input logic [2:0] sel,
                               input bit cpol, input bit tail, output int rxc);
        logic [NCS-1:0] ecs;
        logic [DW-1:0]  erx;
        int cs_cnt, bad;
        ecs = exp_cs(sel);
        cs_cnt = 0; bad = 0; rxc = -1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (rx_valid) begin rxc = cyc; break; end
            if (SPI_CS_N == ecs && ecs != {NCS{1'b1}}) cs_cnt++;
            else if (SPI_CS_N != {NCS{1'b1}}) bad++;
        end
        erx = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
        check("rx_timeout", (rxc >= 0), 1);
        check("latency", rxc - acc, XLAT);
        check("rx_data", rx_data, erx);
        check("mosi_word", cap_word, tx);
        check("sclk_edges", s_edges, 2 * DW);
        check("cs_low_cycles", cs_cnt, (sel < NCS) ? XLAT : 0);
        check("cs_wrong", bad, 0);
        check("cs_at_done", SPI_CS_N, {NCS{1'b1}});
        check("mosi_at_done", SPI_MOSI, 0);
        check("sclk_at_done", SPI_CLK, cpol);
        slave_on = 0;
        if (tail) begin
            @(negedge clk);
            check("rx_valid_pulse", rx_valid, 0);
            check("ready_after_done", tx_ready, 1);
        end
    endtask

    // ---------------- stimulus ----------------
    typedef struct {
        logic [DW-1:0] tx;
        logic [DW-1:0] slv;
        bit            cpol, cpha, lsb;
        logic [2:0]    sel;
        logic [DW-1:0] exp_rx;
    } vec_t;

    vec_t vecs[9];

    initial begin
        int acc, rxc, acc2;
        logic [DW-1:0] t, s;
        bit p, h, l;
        logic [2:0] sl;

        vecs[0] = '{8'hA5, 8'h3C, 0, 0, 0, 3'd0, 8'h3C};
        vecs[1] = '{8'h81, 8'h40, 0, 0, 0, 3'd0, 8'h40};
        vecs[2] = '{8'h81, 8'h40, 0, 1, 0, 3'd1, 8'h40};
        vecs[3] = '{8'h81, 8'h40, 1, 0, 0, 3'd0, 8'h40};
        vecs[4] = '{8'h81, 8'h40, 1, 1, 0, 3'd3, 8'h40};
        vecs[5] = '{8'h01, 8'h80, 0, 0, 1, 3'd0, 8'h80};
        vecs[6] = '{8'hC6, 8'h5B, 1, 1, 1, 3'd1, 8'h5B};
        vecs[7] = '{8'h3E, 8'hE7, 0, 0, 0, 3'd2, 8'hE7};
        vecs[8] = '{8'h9D, 8'h62, 0, 1, 0, 3'd5, 8'h62};

        // reset state
        repeat (3) @(negedge clk);
        check("rst_tx_ready", tx_ready, 0);
        check("rst_rx_valid", rx_valid, 0);
        check("rst_rx_data", rx_data, 0);
        check("rst_busy", busy, 0);
        check("rst_sclk", SPI_CLK, 0);
        check("rst_mosi", SPI_MOSI, 0);
        check("rst_cs_n", SPI_CS_N, {NCS{1'b1}});
        rst = 1'b1;
        @(negedge clk);
        check("ready_after_rst", tx_ready, 1);

        for (int i = 0; i < 9; i++) begin
            start_xfer(vecs[i].tx, vecs[i].slv, vecs[i].cpol, vecs[i].cpha, vecs[i].lsb,
                       vecs[i].sel, vecs[i].exp_rx, 0, acc);
            finish_xfer(acc, vecs[i].tx, vecs[i].sel, vecs[i].cpol, 1, rxc);
        end

        for (int i = 0; i < 16; i++) begin
            t = DW'($urandom); s = DW'($urandom);
            p = 1'($urandom); h = 1'($urandom); l = 1'($urandom);
            sl = 3'($urandom_range(0, 5));
            start_xfer(t, s, p, h, l, sl, s, 0, acc);
            finish_xfer(acc, t, sl, p, 1, rxc);
        end

        // reset in the middle of bit 4
        start_xfer(8'h5A, 8'hC3, 0, 0, 0, 3'd0, 8'hC3, 0, acc);
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (s_edges >= 8) break;
        end
        slave_on = 0;
        void'(exp_q.pop_front());
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("abort_cs_n", SPI_CS_N, {NCS{1'b1}});
        check("abort_sclk", SPI_CLK, 0);
        check("abort_busy", busy, 0);
        check("abort_rx_valid", rx_valid, 0);
        check("abort_tx_ready", tx_ready, 0);
        @(negedge clk);
        rst = 1'b1;
        begin
            int seen = 0;
            for (int i = 0; i < 60; i++) begin
                @(negedge clk);
                if (rx_valid) seen++;
            end
            check("abort_no_rx_valid", seen, 0);
        end
        start_xfer(8'h96, 8'h2D, 0, 0, 0, 3'd0, 8'h2D, 0, acc);
        finish_xfer(acc, 8'h96, 3'd0, 0, 1, rxc);

        // back-to-back with tx_valid held high
        start_xfer(8'h11, 8'hB4, 0, 0, 0, 3'd0, 8'hB4, 1, acc);
        tx_data = 8'h22;
        finish_xfer(acc, 8'h11, 3'd0, 0, 0, rxc);
        arm_slave(8'h4B, 0, 0);
        exp_q.push_back(8'h4B);
        acc2 = -1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (tx_ready && tx_valid) begin acc2 = cyc + 1; break; end
        end
        check("b2b_accept_cycle", acc2, rxc + 2);
        @(posedge clk);
        #1;
        tx_valid = 1'b0;
        finish_xfer(acc2, 8'h22, 3'd0, 0, 1, rxc);

`ifdef SPI_LOOPBACK_EN
        loopback = 1'b1;
        for (int i = 0; i < 4; i++) begin
            t = DW'($urandom); h = 1'($urandom); l = 1'($urandom); p = 1'($urandom);
            start_xfer(t, 8'h00, p, h, l, 3'd1, t, 0, acc);
            finish_xfer(acc, t, 3'd1, p, 1, rxc);
        end
        loopback = 1'b0;
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
